// File: rtl/riscv_muldiv_seq.sv
// RV32M iterative multiply/divide sequencer for EX: one bit per cycle on a shared
// 2*WORD_SIZE accumulator, with sign fix-up, divide shortcuts, flush abort and valid/ready result.
module riscv_muldiv_seq #(
    parameter int unsigned WORD_SIZE     = 32,
    parameter int unsigned REGFILE_COUNT = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [2:0]                       op_i,
    input  logic [WORD_SIZE-1:0]             a_i,
    input  logic [WORD_SIZE-1:0]             b_i,
    input  logic [$clog2(REGFILE_COUNT)-1:0] rd_i,
    input  logic                             flush_i,
    output logic                             stall_o,
    output logic                             resp_valid_o,
    input  logic                             resp_ready_i,
    output logic [WORD_SIZE-1:0]             result_o,
    output logic [$clog2(REGFILE_COUNT)-1:0] rd_o
);

    localparam int unsigned CNT_W = $clog2(WORD_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);
    localparam logic [WORD_SIZE-1:0] WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t                   state, state_d;
    op_t                      op_in, op_q;
    logic [CNT_W-1:0]         cnt;
    logic                     sign_a, sign_b;
    logic [WORD_SIZE-1:0]     mag_b;
    logic [2*WORD_SIZE-1:0]   acc;

    logic                     accept, a_signed, b_signed, shortcut;
    logic [WORD_SIZE-1:0]     shortcut_res, mag_a_in, mag_b_in;
    logic [WORD_SIZE-1:0]     mul_addend;
    logic [WORD_SIZE:0]       hi_sum, rem_shift, diff;
    logic [2*WORD_SIZE-1:0]   acc_step, prod;
    logic [WORD_SIZE-1:0]     quo_f, rem_f, fix_res;

    // Request decode, operand magnitudes and single-cycle shortcut results
    always_comb begin
        op_in        = op_t'(op_i);
        accept       = (state == IDLE) && req_valid_i && !flush_i;
        a_signed     = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed     = op_in inside {OP_MULH, OP_DIV, OP_REM};
        mag_a_in     = (a_signed && a_i[WORD_SIZE-1]) ? -a_i : a_i;
        mag_b_in     = (b_signed && b_i[WORD_SIZE-1]) ? -b_i : b_i;
        shortcut     = 1'b0;
        shortcut_res = '0;
        if (op_i[2] && (b_i == '0)) begin
            shortcut     = 1'b1;
            shortcut_res = op_i[1] ? a_i : '1;
        end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                     (a_i == WORD_MIN) && (b_i == '1)) begin
            shortcut     = 1'b1;
            shortcut_res = op_i[1] ? '0 : WORD_MIN;
        end
    end

    // acc holds {high, low}: multiply keeps {partial product, multiplier},
    // divide keeps {remainder, dividend shifting out / quotient shifting in}
    always_comb begin
        mul_addend = acc[0] ? mag_b : '0;
        hi_sum     = {1'b0, acc[2*WORD_SIZE-1:WORD_SIZE]} + {1'b0, mul_addend};
        rem_shift  = acc[2*WORD_SIZE-1:WORD_SIZE-1];
        diff       = rem_shift - {1'b0, mag_b};
        if (!op_q[2]) begin
            acc_step = {hi_sum, acc[WORD_SIZE-1:1]};
        end else if (diff[WORD_SIZE]) begin
            acc_step = {rem_shift[WORD_SIZE-1:0], acc[WORD_SIZE-2:0], 1'b0};
        end else begin
            acc_step = {diff[WORD_SIZE-1:0], acc[WORD_SIZE-2:0], 1'b1};
        end
    end

    always_comb begin
        prod  = (sign_a ^ sign_b) ? -acc : acc;
        quo_f = (sign_a ^ sign_b) ? -acc[WORD_SIZE-1:0] : acc[WORD_SIZE-1:0];
        rem_f = sign_a ? -acc[2*WORD_SIZE-1:WORD_SIZE] : acc[2*WORD_SIZE-1:WORD_SIZE];
        unique case (op_q)
            OP_MUL:                       fix_res = prod[WORD_SIZE-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*WORD_SIZE-1:WORD_SIZE];
            OP_DIV, OP_DIVU:              fix_res = quo_f;
            default:                      fix_res = rem_f;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (accept) state_d = shortcut ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_comb begin
        req_ready_o  = (state == IDLE);
        resp_valid_o = (state == DONE);
        unique case (state)
            IDLE:      stall_o = req_valid_i;
            CALC, FIX: stall_o = 1'b1;
            DONE:      stall_o = !resp_ready_i;
            default:   stall_o = 1'b0;
        endcase
        if (flush_i) stall_o = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt      <= '0;
            op_q     <= OP_MUL;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_b    <= '0;
            acc      <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_in;
                        rd_o   <= rd_i;
                        sign_a <= a_signed & a_i[WORD_SIZE-1];
                        sign_b <= b_signed & b_i[WORD_SIZE-1];
                        mag_b  <= mag_b_in;
                        acc    <= {{WORD_SIZE{1'b0}}, mag_a_in};
                        cnt    <= '0;
                        if (shortcut) result_o <= shortcut_res;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX:  result_o <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_seq.sv
// Self-checking bench for riscv_muldiv_seq: directed RV32M vectors, randomized ops against
// an arithmetic reference model, flush, mid-operation reset and result backpressure.
module tb_riscv_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, flush, resp_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        req_ready_o, stall_o, resp_valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int tests_run = 0;
    int failed    = 0;

    riscv_muldiv_seq #(.WORD_SIZE(32), .REGFILE_COUNT(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .op_i(op), .a_i(a), .b_i(b), .rd_i(rd), .flush_i(flush), .stall_o(stall_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready), .result_o(result_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (o)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 32'h0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 32'h0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one request, waits (bounded) for the response, holds backpressure for
    // `hold` cycles, then completes the handshake. Returns observations only.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input int hold,
                         output logic [31:0] res, output logic [4:0] rdo, output int lat,
                         output bit pre_ok, output bit stall_ok, output bit hold_ok, output bit hs_ok);
        op = o; a = x; b = y; rd = r; req_valid = 1'b1; resp_ready = 1'b0;
        #1;
        pre_ok   = (req_ready_o === 1'b1) && (stall_o === 1'b1);
        stall_ok = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid_o !== 1'b1 && lat < 200) begin
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (resp_valid_o !== 1'b1) begin
            res = 'x; rdo = 'x; hold_ok = 1'b0; hs_ok = 1'b0;
            return;
        end
        res = result_o; rdo = rd_o; hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (result_o !== res || rd_o !== rdo || resp_valid_o !== 1'b1 ||
                stall_o !== 1'b1 || req_ready_o !== 1'b0) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        hs_ok = (stall_o === 1'b0) && (resp_valid_o === 1'b1) && (result_o === res);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        hs_ok = hs_ok && (resp_valid_o === 1'b0) && (req_ready_o === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        op = 3'd0; a = '0; b = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready_o, resp_valid_o, stall_o} !== 3'b100) begin
            failed++;
            $display("FAIL reset_ctrl: {ready,valid,stall}=%b required 100", {req_ready_o, resp_valid_o, stall_o});
        end
        tests_run++;
        if (result_o !== 32'h0 || rd_o !== 5'h0) begin
            failed++;
            $display("FAIL reset_data: result=%h rd=%0d required 0/0", result_o, rd_o);
        end
        req_valid = 1'b1;
        #1;
        tests_run++;
        if (stall_o !== 1'b1) begin
            failed++;
            $display("FAIL reset_stall_req: stall=%b required 1", stall_o);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x, y, exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[12];
        logic [31:0] res; logic [4:0] rdo; int lat; bit pre_ok, stall_ok, hold_ok, hs_ok;
        v[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        v[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        v[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        v[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        v[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
        v[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
        v[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        34};
        v[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         34};
        v[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        v[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
        v[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        v[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        for (int i = 0; i < 12; i++) begin
            do_op(v[i].o, v[i].x, v[i].y, 5'(i + 1), 0, res, rdo, lat, pre_ok, stall_ok, hold_ok, hs_ok);
            tests_run++;
            if (res !== v[i].exp) begin
                failed++;
                $display("FAIL dir_result[%0d] op=%0d: got %h required %h", i, v[i].o, res, v[i].exp);
            end
            tests_run++;
            if (lat !== v[i].lat) begin
                failed++;
                $display("FAIL dir_latency[%0d]: got %0d edges required %0d", i, lat, v[i].lat);
            end
            tests_run++;
            if (rdo !== 5'(i + 1)) begin
                failed++;
                $display("FAIL dir_rd[%0d]: got %0d required %0d", i, rdo, i + 1);
            end
            tests_run++;
            if ({pre_ok, stall_ok, hs_ok} !== 3'b111) begin
                failed++;
                $display("FAIL dir_stall_hs[%0d]: {accept,busy,handshake} ok=%b required 111", i, {pre_ok, stall_ok, hs_ok});
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, res; logic [2:0] o; logic [4:0] r;
        logic [4:0] rdo; int lat; bit pre_ok, stall_ok, hold_ok, hs_ok;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            r = 5'($urandom);
            do_op(o, x, y, r, 0, res, rdo, lat, pre_ok, stall_ok, hold_ok, hs_ok);
            tests_run++;
            if (res !== model(o, x, y) || rdo !== r || lat !== model_lat(o, x, y)) begin
                failed++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: result=%h rd=%0d lat=%0d required %h/%0d/%0d",
                         i, o, x, y, res, rdo, lat, model(o, x, y), r, model_lat(o, x, y));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res; logic [4:0] rdo; int lat; bit pre_ok, stall_ok, hold_ok, hs_ok, seen;
        op = 3'd5; a = 32'hFFFF_0000; b = 32'd3; rd = 5'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        tests_run++;
        if (stall_o !== 1'b0) begin
            failed++;
            $display("FAIL flush_stall: stall=%b required 0", stall_o);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        tests_run++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            failed++;
            $display("FAIL flush_idle: ready=%b valid=%b required 1/0", req_ready_o, resp_valid_o);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid_o === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            failed++;
            $display("FAIL flush_no_resp: resp_valid seen=%b required 0", seen);
        end
        // Flush must win over a simultaneous request in IDLE
        op = 3'd0; a = 32'd3; b = 32'd4; req_valid = 1'b1; flush = 1'b1;
        #1;
        tests_run++;
        if (stall_o !== 1'b0) begin
            failed++;
            $display("FAIL flush_idle_stall: stall=%b required 0", stall_o);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        tests_run++;
        if (req_ready_o !== 1'b1) begin
            failed++;
            $display("FAIL flush_beats_req: ready=%b required 1", req_ready_o);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid_o === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            failed++;
            $display("FAIL flush_req_no_resp: resp_valid seen=%b required 0", seen);
        end
        do_op(3'd5, 32'd9, 32'd3, 5'd4, 0, res, rdo, lat, pre_ok, stall_ok, hold_ok, hs_ok);
        tests_run++;
        if (res !== 32'd3 || lat !== 34) begin
            failed++;
            $display("FAIL post_flush_divu: result=%h lat=%0d required 3/34", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic [4:0] rdo; int lat; bit pre_ok, stall_ok, hold_ok, hs_ok, seen;
        op = 3'd0; a = 32'd11; b = 32'd13; rd = 5'd17; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (result_o !== 32'h0 || rd_o !== 5'h0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failed++;
            $display("FAIL mid_reset: result=%h rd=%0d valid=%b ready=%b required 0/0/0/1",
                     result_o, rd_o, resp_valid_o, req_ready_o);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid_o === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            failed++;
            $display("FAIL mid_reset_no_resp: resp_valid seen=%b required 0", seen);
        end
        do_op(3'd0, 32'd11, 32'd13, 5'd17, 0, res, rdo, lat, pre_ok, stall_ok, hold_ok, hs_ok);
        tests_run++;
        if (res !== 32'd143 || rdo !== 5'd17) begin
            failed++;
            $display("FAIL post_reset_mul: result=%h rd=%0d required 0000008f/17", res, rdo);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res; logic [4:0] rdo; int lat; bit pre_ok, stall_ok, hold_ok, hs_ok;
        do_op(3'd5, 32'd100, 32'd7, 5'd5, 5, res, rdo, lat, pre_ok, stall_ok, hold_ok, hs_ok);
        tests_run++;
        if (res !== 32'd14 || rdo !== 5'd5) begin
            failed++;
            $display("FAIL bp_result: result=%h rd=%0d required 0000000e/5", res, rdo);
        end
        tests_run++;
        if (hold_ok !== 1'b1) begin
            failed++;
            $display("FAIL bp_hold_stable: ok=%b required 1", hold_ok);
        end
        tests_run++;
        if (hs_ok !== 1'b1) begin
            failed++;
            $display("FAIL bp_handshake_idle: ok=%b required 1", hs_ok);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
